seq_alu: RTL and testbench

Multi-cycle, handshaked ALU for the arithmetic section. It accepts one operand pair and opcode per transaction over a valid/ready input channel. It computes AND/OR/ADD in a single step, and MUL/DIV iteratively (shift-add, restoring division). It returns the result over a valid/ready output channel. It sits between a command issuer and a result consumer, and replaces free-running combinational outputs with one registered, flow-controlled result per command.

---
 rtl/seq_alu_pkg.sv | 17 +
 rtl/seq_alu_iter.sv | 82 ++++++++
 rtl/seq_alu.sv | 137 +++++++++++++
 tb/tb_seq_alu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings and controller state type for seq_alu.
// Command issuers and benches import the opcodes from here.
package seq_alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative MUL (shift-add) / DIV (restoring) datapath: one iteration per step_i, W steps total.
// No backpressure of its own; the controller decides when to load and step.
module seq_alu_iter #(
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic           step_i,
    input  logic           div_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           last_o,
    output logic [2*W-1:0] result_o,
    output logic [W-1:0]   rem_o
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic          div_q, div_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic [W-1:0]  divisor_q, divisor_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W:0] mul_sum;
    logic [W:0] trial;
    logic [W:0] diff;
    logic       fits;

    // acc is the product's upper half for MUL and the partial remainder for DIV;
    // opnd shifts the multiplier out (MUL) or the dividend out / quotient in (DIV).
    assign mul_sum = {1'b0, acc_q} + (opnd_q[0] ? {1'b0, divisor_q} : '0);
    assign trial   = {acc_q, opnd_q[W-1]};
    assign diff    = trial - {1'b0, divisor_q};
    assign fits    = (trial >= {1'b0, divisor_q});

    always_comb begin
        div_d     = div_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            div_d     = div_i;
            acc_d     = '0;
            opnd_d    = a_i;
            divisor_d = b_i;
            cnt_d     = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + CW'(1);
            if (div_q) begin
                acc_d  = fits ? diff[W-1:0] : trial[W-1:0];
                opnd_d = {opnd_q[W-2:0], fits};
            end else begin
                acc_d  = mul_sum[W:1];
                opnd_d = {mul_sum[0], opnd_q[W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
        end else begin
            div_q     <= div_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
        end
    end

    assign last_o   = (cnt_q == LAST);
    assign result_o = div_q ? {{W{1'b0}}, opnd_q} : {acc_q, opnd_q};
    assign rem_o    = div_q ? acc_q : '0;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: AND/OR/ADD/error cases ready 1 cycle after accept, MUL/DIV after W+1.
// One command in flight; result held in DONE until out_ready, in_ready only in IDLE.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2:0]     op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic [W-1:0]   remainder,
    output logic           err
);
    state_t state_q, state_d;

    logic [2*W-1:0] result_q, result_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           err_q, err_d;
    logic           use_iter_q, use_iter_d;

    logic           accept;
    logic           iter_op;
    logic           it_load;
    logic           it_step;
    logic           it_last;
    logic [W:0]     sum;
    logic [2*W-1:0] it_result;
    logic [W-1:0]   it_rem;

    assign accept  = in_valid && (state_q == IDLE);
    assign iter_op = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    assign sum     = {1'b0, a} + {1'b0, b};

    always_comb begin
        state_d = state_q;
        it_load = 1'b0;
        it_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    it_load = iter_op;
                    state_d = iter_op ? EXEC : DONE;
                end
            end
            EXEC: begin
                it_step = 1'b1;
                if (it_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Single-step results and error outcomes are captured at accept time.
    always_comb begin
        result_d   = result_q;
        rem_d      = rem_q;
        err_d      = err_q;
        use_iter_d = use_iter_q;
        if (accept) begin
            result_d   = '0;
            rem_d      = '0;
            err_d      = 1'b0;
            use_iter_d = iter_op;
            case (op)
                OP_AND: result_d = {{W{1'b0}}, a & b};
                OP_OR:  result_d = {{W{1'b0}}, a | b};
                OP_ADD: result_d = {{(W-1){1'b0}}, sum};
                OP_MUL: result_d = '0;
                OP_DIV: begin
                    if (b == '0) begin
                        result_d = '1;
                        rem_d    = a;
                        err_d    = 1'b1;
                    end
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q   <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            use_iter_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            rem_q      <= rem_d;
            err_q      <= err_d;
            use_iter_q <= use_iter_d;
        end
    end

    seq_alu_iter #(.W(W)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (it_load),
        .step_i   (it_step),
        .div_i    (op == OP_DIV),
        .a_i      (a),
        .b_i      (b),
        .last_o   (it_last),
        .result_o (it_result),
        .rem_o    (it_rem)
    );

    // Iterative values are only exposed once DONE, so partial products never leak out.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = (use_iter_q && state_q == DONE) ? it_result : result_q;
    assign remainder = (use_iter_q && state_q == DONE) ? it_rem : rem_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed/table-driven bench for seq_alu at W=2, including back-pressure and mid-operation reset.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 2;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic [W-1:0]   remainder;
    logic           err;

    int tests    = 0;
    int fails    = 0;
    int issued   = 0;
    int aborted  = 0;
    int accepted = 0;
    int handshakes = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2:0]     op;
        logic [2*W-1:0] res;
        logic [W-1:0]   rem;
        logic           err;
        int             lat;
    } vec_t;

    localparam int NH = 14;
    vec_t hand [NH];

    seq_alu #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .remainder (remainder),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && in_valid && in_ready) accepted <= accepted + 1;
        if (!rst && out_valid && out_ready) handshakes <= handshakes + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(input int ia, input int ib, input int iop,
                                  output int r, output int rm, output int e, output int lat);
        r = 0; rm = 0; e = 0; lat = 1;
        case (iop)
            0: r = ia & ib;
            1: r = ia | ib;
            2: r = ia + ib;
            3: begin r = ia * ib; lat = W + 1; end
            4: begin
                if (ib == 0) begin
                    r = (1 << (2 * W)) - 1; rm = ia; e = 1;
                end else begin
                    r = ia / ib; rm = ia % ib; lat = W + 1;
                end
            end
            default: e = 1;
        endcase
    endfunction

    task automatic run_cmd(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic [2:0] top,
                           input logic [2*W-1:0] eres, input logic [W-1:0] erem, input logic eerr,
                           input int elat, input bit bp);
        int  k;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 1);
        a = ta; b = tb_b; op = top; in_valid = 1'b1;
        out_ready = 1'b0;
        issued++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0; seen = 0; busy_ok = 1;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (out_valid) seen = 1;
            else if (in_ready) busy_ok = 0;
        end
        if (!seen) begin
            check("out_valid_timeout", 32'(k), 32'(elat));
            return;
        end
        check("latency", 32'(k), 32'(elat));
        check("busy_in_ready_low", 32'(busy_ok), 1);
        for (int j = 0; j < 12; j++) begin
            check("result", 32'(result), 32'(eres));
            check("remainder", 32'(remainder), 32'(erem));
            check("err", 32'(err), 32'(eerr));
            check("done_in_ready", 32'(in_ready), 0);
            out_ready = (bp && j < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) break;
            @(negedge clk);
            check("held_out_valid", 32'(out_valid), 1);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("after_consume_in_ready", 32'(in_ready), 1);
        check("after_consume_out_valid", 32'(out_valid), 0);
    endtask

    initial begin
        int r, rm, e, lat;

        hand[0]  = '{2'd3, 2'd3, OP_MUL, 4'd9,  2'd0, 1'b0, 3};
        hand[1]  = '{2'd3, 2'd2, OP_DIV, 4'd1,  2'd1, 1'b0, 3};
        hand[2]  = '{2'd3, 2'd0, OP_DIV, 4'd15, 2'd3, 1'b1, 1};
        hand[3]  = '{2'd3, 2'd3, 3'b101, 4'd0,  2'd0, 1'b1, 1};
        hand[4]  = '{2'd1, 2'd2, 3'b110, 4'd0,  2'd0, 1'b1, 1};
        hand[5]  = '{2'd2, 2'd1, 3'b111, 4'd0,  2'd0, 1'b1, 1};
        hand[6]  = '{2'd2, 2'd3, OP_AND, 4'd2,  2'd0, 1'b0, 1};
        hand[7]  = '{2'd1, 2'd2, OP_OR,  4'd3,  2'd0, 1'b0, 1};
        hand[8]  = '{2'd3, 2'd1, OP_ADD, 4'd4,  2'd0, 1'b0, 1};
        hand[9]  = '{2'd2, 2'd3, OP_MUL, 4'd6,  2'd0, 1'b0, 3};
        hand[10] = '{2'd2, 2'd3, OP_DIV, 4'd0,  2'd2, 1'b0, 3};
        hand[11] = '{2'd0, 2'd1, OP_DIV, 4'd0,  2'd0, 1'b0, 3};
        hand[12] = '{2'd0, 2'd3, OP_MUL, 4'd0,  2'd0, 1'b0, 3};
        hand[13] = '{2'd3, 2'd1, OP_DIV, 4'd3,  2'd0, 1'b0, 3};

        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_result", 32'(result), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_err", 32'(err), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NH; i++) begin
            run_cmd(hand[i].a, hand[i].b, hand[i].op, hand[i].res, hand[i].rem,
                    hand[i].err, hand[i].lat, 1'b0);
        end

        // ADD held under back-pressure while a stray AND command is offered.
        @(negedge clk);
        check("bp_idle_in_ready", 32'(in_ready), 1);
        a = 2'd3; b = 2'd3; op = OP_ADD; in_valid = 1'b1; out_ready = 1'b0;
        issued++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_result", 32'(result), 6);
            check("bp_err", 32'(err), 0);
            check("bp_in_ready", 32'(in_ready), 0);
            if (i == 1) begin in_valid = 1'b1; op = OP_AND; end
            if (i == 3) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_consumed_out_valid", 32'(out_valid), 0);
        check("bp_consumed_in_ready", 32'(in_ready), 1);
        run_cmd(2'd3, 2'd3, OP_AND, 4'd3, 2'd0, 1'b0, 1, 1'b0);

        // Reset in the second EXEC cycle of a MUL.
        @(negedge clk);
        a = 2'd3; b = 2'd3; op = OP_MUL; in_valid = 1'b1; out_ready = 1'b1;
        issued++; aborted++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 1);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_result", 32'(result), 0);
        check("abort_remainder", 32'(remainder), 0);
        check("abort_err", 32'(err), 0);
        @(posedge clk);
        #1 check("abort_held_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_abort_out_valid", 32'(out_valid), 0);
        run_cmd(2'd2, 2'd3, OP_MUL, 4'd6, 2'd0, 1'b0, 3, 1'b0);

        for (int o = 0; o < 5; o++) begin
            for (int ia = 0; ia < 4; ia++) begin
                for (int ib = 0; ib < 4; ib++) begin
                    model(ia, ib, o, r, rm, e, lat);
                    run_cmd(W'(ia), W'(ib), 3'(o), (2*W)'(r), W'(rm), 1'(e), lat, 1'b1);
                end
            end
        end

        @(negedge clk);
        check("accepted_count", 32'(accepted), 32'(issued));
        check("handshake_count", 32'(handshakes), 32'(issued - aborted));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
